// File: rtl/apb_slave_module.sv
// APB front end: decodes/validates region, issues single-cycle register-file accesses, pulses start.
// Latency: fixed 3 cycles per transfer (SETUP, ACCESS, RESP); one wait state, write strobe in ACCESS.
// Backpressure: none from the register file; pready is asserted only in RESP, psel drop aborts.
module apb_slave_module #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int LOG2      = $clog2(MAX_DIM)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  input  logic                  busy_i,
  input  logic [BUS_WIDTH-1:0]  rf_data_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [BUS_WIDTH-1:0]  data_o,
  output logic                  write_enable_o,
  output logic [MAX_DIM-1:0]    strobe_o,
  output logic                  start_bit_o
);

  localparam logic [4:0] REG_CONTROL = 5'h00;
  localparam logic [4:0] REG_OP_A    = 5'h04;
  localparam logic [4:0] REG_OP_B    = 5'h08;
  localparam logic [4:0] REG_FLAGS   = 5'h0C;
  localparam logic [4:0] REG_SP      = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0]  r_data;
  logic [MAX_DIM-1:0]    r_strb;
  logic                  r_write;
  logic                  r_err;
  logic [BUS_WIDTH-1:0]  r_prdata;
  logic                  w_setup;
  logic                  w_err;
  logic                  w_hi_ctl;
  logic                  w_hi_op;
  logic                  w_hi_sp;

  // Row-index space grows per region: scalar regs have none, operands one index, SP two.
  assign w_hi_ctl = (paddr_i >> 5) != '0;
  assign w_hi_op  = (paddr_i >> (5 + LOG2)) != '0;
  assign w_hi_sp  = (paddr_i >> (5 + 2 * LOG2)) != '0;
  assign w_setup  = (r_state == ST_IDLE) && psel_i && !penable_i;

  // Validate the access from SETUP-phase address, direction and engine busy state.
  always_comb begin
    w_err = 1'b0;
    case (paddr_i[4:0])
      REG_CONTROL:        w_err = w_hi_ctl | (pwrite_i & busy_i);
      REG_OP_A, REG_OP_B: w_err = w_hi_op  | (pwrite_i & busy_i);
      REG_FLAGS:          w_err = w_hi_ctl | pwrite_i;
      REG_SP:             w_err = w_hi_sp  | pwrite_i;
      default:            w_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: losing psel in ACCESS or RESP abandons the transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_setup) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = psel_i ? ST_RESP : ST_IDLE;
      ST_RESP:   if (!psel_i || penable_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the transfer operands and verdict in SETUP; they hold until the next SETUP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_setup) begin
      r_addr  <= paddr_i;
      r_data  <= pwdata_i;
      r_strb  <= pstrb_i;
      r_write <= pwrite_i;
      r_err   <= w_err;
    end
  end

  // Capture read data at the ACCESS->RESP edge; writes and rejected accesses return zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               r_prdata <= '0;
    else if ((r_state == ST_ACCESS) && psel_i) r_prdata <= (r_write || r_err) ? '0 : rf_data_i;
  end

  // Outputs: write strobe only in ACCESS with psel still held; response flags only in RESP.
  always_comb begin
    write_enable_o = (r_state == ST_ACCESS) && r_write && !r_err && psel_i;
    start_bit_o    = write_enable_o && (r_addr[4:0] == REG_CONTROL) && r_data[0];
    pready_o       = (r_state == ST_RESP);
    pslverr_o      = (r_state == ST_RESP) && r_err;
  end

  assign prdata_o  = r_prdata;
  assign address_o = r_addr;
  assign data_o    = r_data;
  assign strobe_o  = r_strb;

endmodule

// File: doc/apb_slave_module.md
# apb_slave_module

Bus front end of the matrix-multiplication accelerator, placed directly upstream of `register_file_module`. It terminates APB transfers, decodes and validates the target region, and issues single-cycle read/write accesses on the register-file port (`address`, `data`, `write_enable`, `strobe`). It also pulses the start strobe when the host writes CONTROL bit 0, and rejects illegal accesses with `pslverr`.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: matrix element width.
- `BUS_WIDTH`, default 64: APB data width and register-file data width.
- `ADDR_WIDTH`, default 32: APB address width.
- Derived: `MAX_DIM = BUS_WIDTH/DATA_WIDTH`; `LOG2 = $clog2(MAX_DIM)`.

**Ports**
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `psel_i` input 1: APB select.
- `penable_i` input 1: APB enable.
- `pwrite_i` input 1: APB direction, 1 = write.
- `paddr_i` input ADDR_WIDTH: APB address.
- `pwdata_i` input BUS_WIDTH: APB write data.
- `pstrb_i` input MAX_DIM: element strobes, one bit per element.
- `busy_i` input 1: engine running; driven by the control start bit.
- `rf_data_i` input BUS_WIDTH: register-file read data, combinational from `address_o`.
- `prdata_o` output BUS_WIDTH: APB read data.
- `pready_o` output 1: APB ready.
- `pslverr_o` output 1: APB error.
- `address_o` output ADDR_WIDTH: register-file address.
- `data_o` output BUS_WIDTH: register-file write data.
- `write_enable_o` output 1: register-file write strobe.
- `strobe_o` output MAX_DIM: register-file element strobes.
- `start_bit_o` output 1: start pulse to the control register.

## Operation

**FSM states:** IDLE, ACCESS, RESP.
- IDLE → ACCESS when `psel_i & ~penable_i` (SETUP phase).
  - Latch `paddr_i`, `pwdata_i`, `pwrite_i`, `pstrb_i`.
  - Compute `err_q` from `paddr_i`, `pwrite_i`, `busy_i` sampled in the same cycle.
- ACCESS → RESP unconditionally, unless `psel_i` = 0. If `psel_i` = 0: go to IDLE, suppress the write, drop the transfer.
- RESP → IDLE when `psel_i & penable_i`. If `psel_i` = 0: go to IDLE.

**Region decode** uses `paddr[4:0]`: CONTROL 0x00, OPERAND_A 0x04, OPERAND_B 0x08, FLAGS 0x0C, SP 0x10.

**`err_q` = 1 if any of the following holds:**
- `paddr[4:0]` is not one of the five region codes.
- CONTROL or FLAGS with `paddr[ADDR_WIDTH-1:5]` ≠ 0.
- OPERAND_A or OPERAND_B with `paddr[ADDR_WIDTH-1:5+LOG2]` ≠ 0.
- SP with `paddr[ADDR_WIDTH-1:5+2*LOG2]` ≠ 0.
- Write to FLAGS or SP (host read-only).
- Write to CONTROL, OPERAND_A or OPERAND_B while `busy_i` = 1.

**Outputs and side effects:**
- `write_enable_o` = (state == ACCESS) & `pwrite_q` & ~`err_q` & `psel_i`.
- `start_bit_o` = `write_enable_o` & region == CONTROL & `data_o[0]`. It asserts in the same cycle as the write.
- Reads: `prdata_o` is registered from `rf_data_i` at the ACCESS→RESP edge. `prdata_o` = 0 on error or on a write.
- `pready_o` = 1 only in RESP.
- `pslverr_o` = `err_q` in RESP, 0 otherwise.
- `pstrb` = 0 on a legal write is a no-op write (`write_enable_o` pulses with `strobe_o` = 0). It is not an error.
- `address_o`, `data_o` and `strobe_o` hold their latched values from SETUP until the next SETUP.

## Timing

**Reset:**
- Asynchronous; state = IDLE.
- `prdata_o`, `address_o`, `data_o`, `strobe_o` = 0.
- `pready_o`, `pslverr_o`, `write_enable_o`, `start_bit_o` = 0.
- Reset asserted mid-transfer aborts it immediately. No write is issued afterwards.

**Transfer timeline (SETUP cycle = T0):**
- T0: SETUP; operands are latched.
- T1: ACCESS; `write_enable_o` is high for exactly this cycle on a legal write; read data is captured at the end of T1.
- T2: RESP; `pready_o` = 1. The transfer completes at the end of T2.
- One wait state per transfer; every transfer takes 3 cycles.

**Handshake and boundary rules:**
- Back-to-back: a new SETUP is accepted in the cycle after RESP, giving at most one transfer per 3 cycles.
- `penable_i` = 1 seen in IDLE (no SETUP) is ignored; the FSM stays in IDLE.
- `busy_i` is sampled only in SETUP. A rise during ACCESS does not cancel an already-validated write.

## Test plan

- **Reset state:** assert `rst_ni` = 0 mid-ACCESS of a legal write → `write_enable_o` never pulses; all outputs 0; FSM in IDLE.
- **Legal write:** write OPERAND_A row 1 (`paddr` 0x24, `pwdata` 0x0000_0005_0000_0003, `pstrb` 2'b11, `busy_i` 0) → in T1, `write_enable_o` = 1, `address_o` = 0x24, `strobe_o` = 2'b11; in T2, `pready_o` = 1, `pslverr_o` = 0.
- **Start pulse and read:**
  - Write CONTROL 0x0001 → `start_bit_o` is a one-cycle pulse in T1.
  - Read SP `paddr` 0x70 with `rf_data_i` = 0x1234 → `prdata_o` = 0x1234 in T2.
- **Error cases, each with no `write_enable_o` and `pslverr_o` = 1, `prdata_o` = 0 in RESP:**
  - Write to 0x0C.
  - Write to 0x10.
  - Access to 0x14.
  - Access to OPERAND_B row 2 (0x48).
  - Write to 0x04 with `busy_i` = 1.
- **Read while busy:** read of OPERAND_B 0x08 with `busy_i` = 1 → completes without error.
- **Protocol edges:**
  - `psel_i` dropped in ACCESS → FSM in IDLE next cycle, no write, no `pready_o`.
  - Back-to-back writes → second SETUP is accepted the cycle after RESP; two `write_enable_o` pulses 3 cycles apart.
